hhmm_frame_loader: RTL and testbench

Frame controller and parameter loader that sits directly downstream of the Nios offload PIOs. It captures the indexed `mutv` and `pbest` byte streams into shadow banks and times each evaluation frame against the programmed frame duration. It returns the frame-reached flag to the Nios and commits the shadow banks to the active banks that drive the HHMM network at each frame boundary.

---
 rtl/hhmm_pkg.sv | 20 ++
 rtl/offload_capture.sv | 49 ++++
 rtl/hhmm_frame_loader.sv | 98 +++++++++
 tb/tb_hhmm_frame_loader.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/hhmm_pkg.sv
// Shared types and constants for the HHMM frame loader: frame state
// encoding, default widths and the frame-length helper.
package hhmm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_REACHED = 2'd2
    } frame_state_t;

    localparam int DW_DEF = 8;
    localparam int IDX_W  = 8;
    localparam int FD_W   = 16;

    // A programmed duration of zero behaves as a one-cycle frame.
    function automatic logic [FD_W-1:0] frame_len(input logic [FD_W-1:0] d);
        return (d == '0) ? FD_W'(1) : d;
    endfunction

endpackage

// File: rtl/offload_capture.sv
// Indexed offload capture: shadow register file with per-slot seen mask,
// committed into an active bank when the frame controller says so.
module offload_capture
    import hhmm_pkg::*;
#(
    parameter int NP = 11,
    parameter int DW = DW_DEF
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [IDX_W-1:0]   i_index,
    input  logic [DW-1:0]      i_data,
    input  logic               i_commit,
    output logic               o_complete,
    output logic [NP*DW-1:0]   o_bank
);

    logic [NP-1:0][DW-1:0] r_shadow;
    logic [NP-1:0][DW-1:0] r_active;
    logic [NP-1:0]         r_seen;
    logic [NP-1:0]         w_hit;

    // Out-of-range indices simply match no slot.
    always_comb begin
        w_hit = '0;
        for (int k = 0; k < NP; k++) begin
            w_hit[k] = (i_index == IDX_W'(k));
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_shadow <= '0;
            r_active <= '0;
            r_seen   <= '0;
        end else begin
            for (int k = 0; k < NP; k++) begin
                if (w_hit[k]) r_shadow[k] <= i_data;
            end
            // A write on the commit edge survives the clear and counts toward the next frame.
            r_seen <= (i_commit ? '0 : r_seen) | w_hit;
            if (i_commit) r_active <= r_shadow;
        end
    end

    assign o_complete = &r_seen;
    assign o_bank     = r_active;

endmodule

// File: rtl/hhmm_frame_loader.sv
// Frame timer and parameter loader: times each evaluation frame and commits
// the captured mutv/pbest shadow banks to the active banks at frame end.
module hhmm_frame_loader
    import hhmm_pkg::*;
#(
    parameter int NP = 11,
    parameter int DW = DW_DEF
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic               SOFT_RESET,
    input  logic [FD_W-1:0]    FRAME_DURATION,
    input  logic [IDX_W-1:0]   MUTV_INDEX,
    input  logic [DW-1:0]      MUTV_DATA,
    input  logic [IDX_W-1:0]   PBEST_INDEX,
    input  logic [DW-1:0]      PBEST_DATA,
    output logic [NP*DW-1:0]   MUTV_BANK,
    output logic [NP*DW-1:0]   PBEST_BANK,
    output logic               BANK_VALID,
    output logic [FD_W-1:0]    FRAME_COUNT,
    output logic               FRAME_REACHED,
    output logic               LOAD_MISS
);

    frame_state_t    r_state, w_next;
    logic [FD_W-1:0] r_count;
    logic            r_valid;
    logic            r_miss;
    logic            w_term;
    logic            w_commit;
    logic            w_miss;
    logic            w_mutv_cmp;
    logic            w_pbest_cmp;

    // Soft reset outranks the terminal edge, so it also suppresses commit and miss.
    assign w_term   = (r_state == ST_RUN) && !SOFT_RESET
                      && (r_count == frame_len(FRAME_DURATION) - FD_W'(1));
    assign w_commit = w_term && w_mutv_cmp && w_pbest_cmp;
    assign w_miss   = w_term && !(w_mutv_cmp && w_pbest_cmp);

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) r_state <= ST_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:    if (!SOFT_RESET) w_next = ST_RUN;
            ST_RUN:     if (SOFT_RESET)  w_next = ST_IDLE;
                        else if (w_term) w_next = ST_REACHED;
            ST_REACHED: if (SOFT_RESET)  w_next = ST_IDLE;
            default:    w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        FRAME_REACHED = (r_state == ST_REACHED);
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_count <= '0;
            r_valid <= 1'b0;
            r_miss  <= 1'b0;
        end else begin
            if (SOFT_RESET || r_state == ST_IDLE) r_count <= '0;
            else if (r_state == ST_RUN)           r_count <= r_count + FD_W'(1);
            if (w_commit) r_valid <= 1'b1;
            r_miss <= w_miss;
        end
    end

    assign FRAME_COUNT = r_count;
    assign BANK_VALID  = r_valid;
    assign LOAD_MISS   = r_miss;

    offload_capture #(.NP(NP), .DW(DW)) u_mutv (
        .i_clk      (CLK),
        .i_rst      (RESET),
        .i_index    (MUTV_INDEX),
        .i_data     (MUTV_DATA),
        .i_commit   (w_commit),
        .o_complete (w_mutv_cmp),
        .o_bank     (MUTV_BANK)
    );

    offload_capture #(.NP(NP), .DW(DW)) u_pbest (
        .i_clk      (CLK),
        .i_rst      (RESET),
        .i_index    (PBEST_INDEX),
        .i_data     (PBEST_DATA),
        .i_commit   (w_commit),
        .o_complete (w_pbest_cmp),
        .o_bank     (PBEST_BANK)
    );

endmodule

// File: tb/tb_hhmm_frame_loader.sv
// Scoreboard bench for hhmm_frame_loader: each frame's expected commit
// result is queued when its stimulus is driven and checked at frame end.
module tb_hhmm_frame_loader;

    localparam int NP = 11;
    localparam int DW = 8;
    localparam int BW = NP * DW;

    logic          CLK = 1'b0;
    logic          RESET;
    logic          SOFT_RESET;
    logic [15:0]   FRAME_DURATION;
    logic [7:0]    MUTV_INDEX, MUTV_DATA, PBEST_INDEX, PBEST_DATA;
    logic [BW-1:0] MUTV_BANK, PBEST_BANK;
    logic          BANK_VALID;
    logic [15:0]   FRAME_COUNT;
    logic          FRAME_REACHED;
    logic          LOAD_MISS;

    hhmm_frame_loader #(.NP(NP), .DW(DW)) dut (
        .CLK            (CLK),
        .RESET          (RESET),
        .SOFT_RESET     (SOFT_RESET),
        .FRAME_DURATION (FRAME_DURATION),
        .MUTV_INDEX     (MUTV_INDEX),
        .MUTV_DATA      (MUTV_DATA),
        .PBEST_INDEX    (PBEST_INDEX),
        .PBEST_DATA     (PBEST_DATA),
        .MUTV_BANK      (MUTV_BANK),
        .PBEST_BANK     (PBEST_BANK),
        .BANK_VALID     (BANK_VALID),
        .FRAME_COUNT    (FRAME_COUNT),
        .FRAME_REACHED  (FRAME_REACHED),
        .LOAD_MISS      (LOAD_MISS)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic          miss;
        logic          valid;
        logic [BW-1:0] mutv;
        logic [BW-1:0] pbest;
    } exp_t;

    exp_t sb[$];
    int   n_chk = 0;
    int   n_err = 0;
    logic [7:0] em [NP];
    logic [7:0] ep [NP];

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic wr(input int mi, input int md, input int pi, input int pd);
        MUTV_INDEX  = 8'(mi);
        MUTV_DATA   = 8'(md);
        PBEST_INDEX = 8'(pi);
        PBEST_DATA  = 8'(pd);
        step();
    endtask

    task automatic idle_bus();
        MUTV_INDEX  = 8'hFF;
        PBEST_INDEX = 8'hFF;
        MUTV_DATA   = 8'h00;
        PBEST_DATA  = 8'h00;
    endtask

    function automatic logic [BW-1:0] pack(input logic [7:0] a [NP]);
        logic [BW-1:0] v;
        v = '0;
        for (int k = 0; k < NP; k++) v[k*DW +: DW] = a[k];
        return v;
    endfunction

    task automatic push_exp(input logic miss, input logic valid);
        exp_t e;
        e.miss  = miss;
        e.valid = valid;
        e.mutv  = pack(em);
        e.pbest = pack(ep);
        sb.push_back(e);
    endtask

    // Release soft reset and run one frame to REACHED; soft reset stays low.
    task automatic run_frame(input int d);
        int   len;
        exp_t e;
        len = (d == 0) ? 1 : d;
        FRAME_DURATION = 16'(d);
        idle_bus();
        SOFT_RESET = 1'b0;
        for (int n = 1; n <= len; n++) begin
            step();
            if (n == len) chk("reached_early", 128'(FRAME_REACHED), 128'(0));
        end
        step();
        chk("reached_rise", 128'(FRAME_REACHED), 128'(1));
        chk("frame_count", 128'(FRAME_COUNT), 128'(len));
        if (sb.size() == 0) begin
            chk("sb_empty", 128'(1), 128'(0));
        end else begin
            e = sb.pop_front();
            chk("load_miss", 128'(LOAD_MISS), 128'(e.miss));
            chk("bank_valid", 128'(BANK_VALID), 128'(e.valid));
            chk("mutv_bank", 128'(MUTV_BANK), 128'(e.mutv));
            chk("pbest_bank", 128'(PBEST_BANK), 128'(e.pbest));
        end
        step();
        chk("miss_1cyc", 128'(LOAD_MISS), 128'(0));
        chk("count_hold", 128'(FRAME_COUNT), 128'(len));
    endtask

    task automatic back_to_idle();
        SOFT_RESET = 1'b1;
        step();
        chk("idle_reached", 128'(FRAME_REACHED), 128'(0));
        chk("idle_count", 128'(FRAME_COUNT), 128'(0));
    endtask

    initial begin
        RESET = 1'b1;
        SOFT_RESET = 1'b1;
        FRAME_DURATION = 16'd20;
        idle_bus();
        for (int k = 0; k < NP; k++) begin em[k] = 8'h00; ep[k] = 8'h00; end

        // Reset state
        repeat (3) step();
        chk("rst_mutv", 128'(MUTV_BANK), 128'(0));
        chk("rst_pbest", 128'(PBEST_BANK), 128'(0));
        chk("rst_valid", 128'(BANK_VALID), 128'(0));
        chk("rst_count", 128'(FRAME_COUNT), 128'(0));
        chk("rst_reached", 128'(FRAME_REACHED), 128'(0));
        chk("rst_miss", 128'(LOAD_MISS), 128'(0));
        RESET = 1'b0;
        repeat (3) step();
        chk("sr_count", 128'(FRAME_COUNT), 128'(0));
        chk("sr_reached", 128'(FRAME_REACHED), 128'(0));

        // Incomplete bank: slot 10 never written -> miss, nothing committed
        for (int k = 0; k < NP - 1; k++) wr(k, 8'hA0 + k, k, 8'hB0 + k);
        push_exp(1'b1, 1'b0);
        run_frame(5);
        back_to_idle();

        // Full stream, D=20
        for (int r = 0; r < 2; r++)
            for (int k = 0; k < NP; k++) wr(k, k + 1, k, 100);
        for (int k = 0; k < NP; k++) begin em[k] = 8'(k + 1); ep[k] = 8'd100; end
        push_exp(1'b0, 1'b1);
        run_frame(20);
        back_to_idle();

        // Out-of-range indices interleaved with valid ones
        for (int k = 0; k < NP; k++) begin
            wr(k, k * 3 + 7, k, k ^ 8'h55);
            wr($urandom_range(255, 11), 8'hFF, $urandom_range(255, 11), 8'hEE);
        end
        wr(11, 8'hFF, 11, 8'hEE);
        wr(255, 8'hFF, 255, 8'hEE);
        for (int k = 0; k < NP; k++) begin em[k] = 8'(k * 3 + 7); ep[k] = 8'(k ^ 8'h55); end
        push_exp(1'b0, 1'b1);
        run_frame(30);
        back_to_idle();

        // Soft reset at count 7 aborts the frame; the next one commits
        for (int k = 0; k < NP; k++) wr(k, k + 50, k, k + 150);
        idle_bus();
        FRAME_DURATION = 16'd20;
        SOFT_RESET = 1'b0;
        repeat (8) step();
        chk("abort_count7", 128'(FRAME_COUNT), 128'(7));
        SOFT_RESET = 1'b1;
        step();
        chk("abort_count", 128'(FRAME_COUNT), 128'(0));
        chk("abort_reached", 128'(FRAME_REACHED), 128'(0));
        chk("abort_miss", 128'(LOAD_MISS), 128'(0));
        step();
        chk("abort_miss2", 128'(LOAD_MISS), 128'(0));
        chk("abort_mutv", 128'(MUTV_BANK), 128'(pack(em)));
        for (int k = 0; k < NP; k++) begin em[k] = 8'(k + 50); ep[k] = 8'(k + 150); end
        push_exp(1'b0, 1'b1);
        run_frame(20);
        back_to_idle();

        // Zero duration behaves as one cycle, then async reset in REACHED
        for (int k = 0; k < NP; k++) wr(k, k + 200, k, 255 - k);
        for (int k = 0; k < NP; k++) begin em[k] = 8'(k + 200); ep[k] = 8'(255 - k); end
        push_exp(1'b0, 1'b1);
        run_frame(0);
        #2;
        RESET = 1'b1;
        #1;
        chk("arst_mutv", 128'(MUTV_BANK), 128'(0));
        chk("arst_pbest", 128'(PBEST_BANK), 128'(0));
        chk("arst_valid", 128'(BANK_VALID), 128'(0));
        chk("arst_count", 128'(FRAME_COUNT), 128'(0));
        chk("arst_reached", 128'(FRAME_REACHED), 128'(0));
        chk("arst_miss", 128'(LOAD_MISS), 128'(0));
        chk("sb_drained", 128'(sb.size()), 128'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
